// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encoding, controller state encoding and small decode helpers.
package mul_div_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Signed variants work on magnitudes and correct the sign afterwards.
  function automatic logic is_signed(input logic [1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_sign_fix.sv
// Conditional two's-complement negation of a {hi, lo} pair. With wide_i set
// the pair is treated as one 2*WIDTH value (product) negated by neg_hi_i;
// otherwise each half is negated on its own flag (operands, quotient/remainder).
module mul_div_sign_fix #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             neg_hi_i,
  input  logic             neg_lo_i,
  input  logic             wide_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0] wide_neg_s;

  // Select negated or pass-through halves according to the requested mode.
  always_comb begin
    wide_neg_s = (~{hi_i, lo_i}) + W2'(1);
    if (wide_i) begin
      if (neg_hi_i) begin
        {hi_o, lo_o} = wide_neg_s;
      end else begin
        {hi_o, lo_o} = {hi_i, lo_i};
      end
    end else begin
      hi_o = neg_hi_i ? ((~hi_i) + WIDTH'(1)) : hi_i;
      lo_o = neg_lo_i ? ((~lo_i) + WIDTH'(1)) : lo_i;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, producing a double-width {hi, lo} result.
// Optional build macro MUL_DIV_EARLY_OUT_EN: multiplies finish as soon as the
// remaining multiplier bits are zero.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int W2 = 2 * WIDTH;

  state_e           state_q;
  logic [1:0]       op_q;
  logic             sgn_hi_q, sgn_lo_q;
  logic [W2-1:0]    acc_q, acc_d;     // MUL: product; DIV: remainder in low half
  logic [W2-1:0]    aux_q, aux_d;     // MUL: shifted multiplicand; DIV: divisor
  logic [WIDTH-1:0] mpl_q, mpl_d;     // MUL: multiplier; DIV: dividend -> quotient
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] res_hi_q, res_lo_q;

  logic             signed_op_s;
  logic [WIDTH-1:0] abs_a_s, abs_b_s;
  logic [WIDTH-1:0] fix_hi_in_s, fix_lo_in_s, fix_hi_s, fix_lo_s;
  logic [WIDTH:0]   div_shift_s, div_diff_s;
  logic             last_step_s;

  assign signed_op_s = is_signed(op);

  mul_div_sign_fix #(.WIDTH(WIDTH)) u_opnd_fix (
    .hi_i     (a),
    .lo_i     (b),
    .neg_hi_i (signed_op_s & a[WIDTH-1]),
    .neg_lo_i (signed_op_s & b[WIDTH-1]),
    .wide_i   (1'b0),
    .hi_o     (abs_a_s),
    .lo_o     (abs_b_s)
  );

  assign fix_hi_in_s = is_div(op_q) ? acc_q[WIDTH-1:0] : acc_q[W2-1:WIDTH];
  assign fix_lo_in_s = is_div(op_q) ? mpl_q : acc_q[WIDTH-1:0];

  mul_div_sign_fix #(.WIDTH(WIDTH)) u_res_fix (
    .hi_i     (fix_hi_in_s),
    .lo_i     (fix_lo_in_s),
    .neg_hi_i (sgn_hi_q),
    .neg_lo_i (sgn_lo_q),
    .wide_i   (~is_div(op_q)),
    .hi_o     (fix_hi_s),
    .lo_o     (fix_lo_s)
  );

  // One iteration of shift-add multiply or restoring shift-subtract divide.
  always_comb begin
    acc_d       = acc_q;
    aux_d       = aux_q;
    mpl_d       = mpl_q;
    div_shift_s = {acc_q[WIDTH-1:0], mpl_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, aux_q[WIDTH-1:0]};
    if (is_div(op_q)) begin
      if (div_diff_s[WIDTH]) begin
        acc_d = {{WIDTH{1'b0}}, div_shift_s[WIDTH-1:0]};
      end else begin
        acc_d = {{WIDTH{1'b0}}, div_diff_s[WIDTH-1:0]};
      end
      mpl_d = {mpl_q[WIDTH-2:0], ~div_diff_s[WIDTH]};
    end else begin
      if (mpl_q[0]) begin
        acc_d = acc_q + aux_q;
      end else begin
        acc_d = acc_q;
      end
      aux_d = {aux_q[W2-2:0], 1'b0};
      mpl_d = {1'b0, mpl_q[WIDTH-1:1]};
    end
  end

`ifdef MUL_DIV_EARLY_OUT_EN
  // Multiplicand is pre-shifted, so the product is already aligned once the
  // multiplier runs out of set bits.
  assign last_step_s = (cnt_q == CNT_W'(1)) ||
                       (!is_div(op_q) && (mpl_d == {WIDTH{1'b0}}));
`else
  assign last_step_s = (cnt_q == CNT_W'(1));
`endif

  // Controller FSM with registered busy/done/result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      sgn_hi_q <= 1'b0;
      sgn_lo_q <= 1'b0;
      acc_q    <= {W2{1'b0}};
      aux_q    <= {W2{1'b0}};
      mpl_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      res_hi_q <= {WIDTH{1'b0}};
      res_lo_q <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start && !flush) begin
            op_q <= op;
            if (is_div(op) && (b == {WIDTH{1'b0}})) begin
              res_hi_q <= a;
              res_lo_q <= {WIDTH{1'b1}};
              dbz_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              dbz_q   <= 1'b0;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_W'(WIDTH);
              acc_q   <= {W2{1'b0}};
              state_q <= ST_CALC;
              if (is_div(op)) begin
                aux_q    <= {{WIDTH{1'b0}}, abs_b_s};
                mpl_q    <= abs_a_s;
                sgn_hi_q <= signed_op_s & a[WIDTH-1];
                sgn_lo_q <= signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
              end else begin
                aux_q    <= {{WIDTH{1'b0}}, abs_a_s};
                mpl_q    <= abs_b_s;
                sgn_hi_q <= signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                sgn_lo_q <= signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
              end
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            acc_q <= acc_d;
            aux_q <= aux_d;
            mpl_q <= mpl_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_step_s) begin
              state_q <= ST_FIXUP;
            end
          end
        end
        ST_FIXUP: begin
          busy_q <= 1'b0;
          if (flush) begin
            state_q <= ST_IDLE;
          end else begin
            res_hi_q <= fix_hi_s;
            res_lo_q <= fix_lo_s;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_hi   = res_hi_q;
  assign result_lo   = res_lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=16): directed and random
// operations against an arithmetic reference model, plus flush/reset cases.
module tb_mul_div_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_hi, result_lo;

  int errors = 0;
  int checks = 0;

  // Model view of the most recent completed result.
  logic [15:0] last_hi, last_lo;
  logic        last_dz;

  logic [1:0]  d_ops [10] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11};
  logic [15:0] d_as  [10] = '{16'hFFFF, 16'hFFFD, 16'd100, 16'hFFF9, 16'h8000, 16'h1234, 16'h0003, 16'h8000, 16'h8000, 16'h00FF};
  logic [15:0] d_bs  [10] = '{16'hFFFF, 16'h0005, 16'd7, 16'h0002, 16'hFFFF, 16'h0000, 16'h0005, 16'h0000, 16'h8000, 16'h0010};

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .result_hi   (result_hi),
    .result_lo   (result_lo),
    .div_by_zero (div_by_zero)
  );

  // Reference arithmetic from the operation definitions.
  task automatic ref_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] hi, output logic [15:0] lo, output logic dz,
                        output int lat);
    int          sp, sa, sb, q, r;
    logic [31:0] pu;
    logic [15:0] mag;
    dz  = 1'b0;
    lat = W + 2;
    case (o)
      2'b00: begin
        sp = int'($signed(x)) * int'($signed(y));
        hi = sp[31:16];
        lo = sp[15:0];
      end
      2'b01: begin
        pu = {16'd0, x} * {16'd0, y};
        hi = pu[31:16];
        lo = pu[15:0];
      end
      default: begin
        if (y == 16'd0) begin
          hi  = x;
          lo  = 16'hFFFF;
          dz  = 1'b1;
          lat = 1;
        end else begin
          if (o == 2'b10) begin
            sa = int'($signed(x));
            sb = int'($signed(y));
          end else begin
            sa = int'(x);
            sb = int'(y);
          end
          q  = sa / sb;
          r  = sa % sb;
          hi = r[15:0];
          lo = q[15:0];
        end
      end
    endcase
`ifdef MUL_DIV_EARLY_OUT_EN
    if (!o[1]) begin
      mag = (o == 2'b00 && y[15]) ? (~y + 16'd1) : y;
      lat = 1;
      for (int i = 0; i < 16; i++) if (mag[i]) lat = i + 1;
      lat = lat + 2;
    end
`else
    mag = 16'd0;
`endif
  endtask

  // Issue one operation and wait (bounded) for done; lat=-1 on timeout.
  task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       output int lat, output logic b1, output logic [15:0] rh,
                       output logic [15:0] rl, output logic dz);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b1  = busy;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    rh = result_hi;
    rl = result_lo;
    dz = div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = 16'd0; b = 16'd0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    checks++; if (result_hi !== 16'd0) begin errors++; $display("FAIL reset_hi got %h want 0000", result_hi); end
    checks++; if (result_lo !== 16'd0) begin errors++; $display("FAIL reset_lo got %h want 0000", result_lo); end
    rst = 1'b1;
    @(negedge clk);
    last_hi = 16'd0; last_lo = 16'd0; last_dz = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] eh, el, rh, rl;
    logic        ed, dz, b1;
    int          el_lat, lat;
    for (int i = 0; i < 10; i++) begin
      ref_op(d_ops[i], d_as[i], d_bs[i], eh, el, ed, el_lat);
      do_op(d_ops[i], d_as[i], d_bs[i], lat, b1, rh, rl, dz);
      checks++; if (lat != el_lat) begin errors++; $display("FAIL dir_latency #%0d got %0d want %0d", i, lat, el_lat); end
      checks++; if (b1 !== (el_lat != 1)) begin errors++; $display("FAIL dir_busy #%0d got %b want %b", i, b1, (el_lat != 1)); end
      checks++; if (rh !== eh) begin errors++; $display("FAIL dir_hi #%0d got %h want %h", i, rh, eh); end
      checks++; if (rl !== el) begin errors++; $display("FAIL dir_lo #%0d got %h want %h", i, rl, el); end
      checks++; if (dz !== ed) begin errors++; $display("FAIL dir_dbz #%0d got %b want %b", i, dz, ed); end
      last_hi = eh; last_lo = el; last_dz = ed;
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    @(negedge clk);
    op = 2'b01; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);                 // cycle 1
    start = 1'b0;
    repeat (4) @(negedge clk);      // cycle 5
    flush = 1'b1;
    @(negedge clk);                 // cycle 6
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    for (int c = 0; c < 25; c++) begin
      if (done) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_done got %0d pulses want 0", seen); end
    checks++; if (result_hi !== last_hi) begin errors++; $display("FAIL flush_hold_hi got %h want %h", result_hi, last_hi); end
    checks++; if (result_lo !== last_lo) begin errors++; $display("FAIL flush_hold_lo got %h want %h", result_lo, last_lo); end
  endtask

  task automatic test_start_while_busy();
    logic [15:0] eh, el;
    logic        ed;
    int          el_lat, lat = -1, extra = 0;
    ref_op(2'b01, 16'h0100, 16'h0100, eh, el, ed, el_lat);
    @(negedge clk);
    op = 2'b01; a = 16'h0100; b = 16'h0100; start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 3) begin
        op = 2'b11; a = 16'h0005; b = 16'h0000; start = 1'b1;
      end
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    checks++; if (lat != el_lat) begin errors++; $display("FAIL busy_start_latency got %0d want %0d", lat, el_lat); end
    checks++; if (result_hi !== eh) begin errors++; $display("FAIL busy_start_hi got %h want %h", result_hi, eh); end
    checks++; if (result_lo !== el) begin errors++; $display("FAIL busy_start_lo got %h want %h", result_lo, el); end
    checks++; if (div_by_zero !== ed) begin errors++; $display("FAIL busy_start_dbz got %b want %b", div_by_zero, ed); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL busy_start_queued got %0d active cycles want 0", extra); end
    last_hi = eh; last_lo = el; last_dz = ed;
  endtask

  task automatic test_flush_start_idle();
    int seen = 0;
    @(negedge clk);
    op = 2'b11; a = 16'h0009; b = 16'h0000; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (busy || done) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_start_active got %0d want 0", seen); end
    checks++; if (result_hi !== last_hi) begin errors++; $display("FAIL flush_start_hi got %h want %h", result_hi, last_hi); end
    checks++; if (div_by_zero !== last_dz) begin errors++; $display("FAIL flush_start_dbz got %b want %b", div_by_zero, last_dz); end
  endtask

  task automatic test_async_reset();
    logic [15:0] eh, el, rh, rl;
    logic        ed, dz, b1;
    int          el_lat, lat, seen = 0;
    @(negedge clk);
    op = 2'b01; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
    checks++; if (result_hi !== 16'd0) begin errors++; $display("FAIL areset_hi got %h want 0000", result_hi); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL areset_no_done got %0d want 0", seen); end
    ref_op(2'b00, 16'h7FFF, 16'h8000, eh, el, ed, el_lat);
    do_op(2'b00, 16'h7FFF, 16'h8000, lat, b1, rh, rl, dz);
    checks++; if (lat != el_lat) begin errors++; $display("FAIL areset_recover_latency got %0d want %0d", lat, el_lat); end
    checks++; if ({rh, rl} !== {eh, el}) begin errors++; $display("FAIL areset_recover_result got %h want %h", {rh, rl}, {eh, el}); end
  endtask

  task automatic test_random();
    logic [15:0] x, y, eh, el, rh, rl;
    logic [1:0]  o;
    logic        ed, dz, b1;
    int          el_lat, lat, sel;
    for (int i = 0; i < 40; i++) begin
      o   = 2'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      y = 16'd0;
      else if (sel < 3)  y = 16'($urandom_range(0, 3));
      else if (sel == 3) y = 16'hFFFF;
      else               y = 16'($urandom);
      x = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      ref_op(o, x, y, eh, el, ed, el_lat);
      do_op(o, x, y, lat, b1, rh, rl, dz);
      checks++; if (lat != el_lat) begin errors++; $display("FAIL rnd_latency op=%0d a=%h b=%h got %0d want %0d", o, x, y, lat, el_lat); end
      checks++; if (rh !== eh) begin errors++; $display("FAIL rnd_hi op=%0d a=%h b=%h got %h want %h", o, x, y, rh, eh); end
      checks++; if (rl !== el) begin errors++; $display("FAIL rnd_lo op=%0d a=%h b=%h got %h want %h", o, x, y, rl, el); end
      checks++; if (dz !== ed) begin errors++; $display("FAIL rnd_dbz op=%0d a=%h b=%h got %b want %b", o, x, y, dz, ed); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_start_while_busy();
    test_flush_start_idle();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
